// File: rtl/reg_bank_switch.sv
// reg_bank_switch
//   Parametrised register bank with a registered N:1 read-select switch.
//   It has one write port, a register-to-register MOV, two independent read
//   ports with write-first bypass, and a registered error pulse.
//
// Ports
//   sys_clk   : clock, all state updates on the rising edge
//   sys_rst   : synchronous reset, active-high
//   wr_en     : write R[wr_sel] with wr_data
//   wr_sel    : write / MOV destination index
//   wr_data   : write data
//   mov_en    : copy R[rd_sel_a] into R[wr_sel] (ignored while wr_en=1)
//   rd_en     : sample both read ports this cycle
//   rd_sel_a  : read port A index, also the MOV source
//   rd_sel_b  : read port B index
//   out_a     : registered read data, port A
//   out_b     : registered read data, port B
//   out_valid : out_a/out_b were updated by the previous cycle's rd_en
//   op_err    : one-cycle pulse for an illegal or conflicting request
module reg_bank_switch #(
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 4,
  parameter int                SEL_W     = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mov_en,
  input  logic              rd_en,
  input  logic [SEL_W-1:0]  rd_sel_a,
  input  logic [SEL_W-1:0]  rd_sel_b,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_valid,
  output logic              op_err
);

  if (NUM_REGS < 2 || SEL_W != $clog2(NUM_REGS)) begin : g_param_check
    $error("reg_bank_switch: SEL_W must equal clog2(NUM_REGS) and NUM_REGS must be >= 2");
  end

  // Index decode done by matching against every legal index, so indices
  // beyond NUM_REGS-1 (non-power-of-2 banks) simply never hit a register.
  function automatic logic in_range(input logic [SEL_W-1:0] sel);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == SEL_W'(i)) hit = 1'b1;
    end
    return hit;
  endfunction

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              wr_ok_p0;
  logic              mov_ok_p0;
  logic              err_p0;
  logic [DATA_W-1:0] mov_src_p0;
  logic [DATA_W-1:0] rd_b_raw_p0;
  logic [DATA_W-1:0] rd_a_p0;
  logic [DATA_W-1:0] rd_b_p0;

  logic [DATA_W-1:0] out_a_p1;
  logic [DATA_W-1:0] out_b_p1;
  logic              vld_p1;
  logic              err_p1;

  // Stage p0: request decode, register read and write-first bypass
  always_comb begin
    mov_src_p0  = '0;
    rd_b_raw_p0 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_a == SEL_W'(i)) mov_src_p0  = regs[i];
      if (rd_sel_b == SEL_W'(i)) rd_b_raw_p0 = regs[i];
    end

    // A write always wins; a MOV only runs when no write is requested.
    wr_ok_p0  = wr_en && in_range(wr_sel);
    mov_ok_p0 = mov_en && !wr_en && in_range(wr_sel) && in_range(rd_sel_a);
    err_p0    = (wr_en && (mov_en || !in_range(wr_sel))) ||
                (mov_en && !wr_en && !(in_range(wr_sel) && in_range(rd_sel_a)));

    // Port A's raw read is the MOV source itself, so a MOV onto rd_sel_a
    // leaves port A unchanged; only the write case needs a bypass there.
    rd_a_p0 = mov_src_p0;
    if (wr_ok_p0 && wr_sel == rd_sel_a) rd_a_p0 = wr_data;

    rd_b_p0 = rd_b_raw_p0;
    if (wr_ok_p0 && wr_sel == rd_sel_b) begin
      rd_b_p0 = wr_data;
    end else if (mov_ok_p0 && wr_sel == rd_sel_b) begin
      rd_b_p0 = mov_src_p0;
    end
  end

  // Stage p1: register bank update and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      out_a_p1 <= '0;
      out_b_p1 <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok_p0 && wr_sel == SEL_W'(i)) begin
          regs[i] <= wr_data;
        end else if (mov_ok_p0 && wr_sel == SEL_W'(i)) begin
          regs[i] <= mov_src_p0;
        end
      end
      if (rd_en) begin
        out_a_p1 <= rd_a_p0;
        out_b_p1 <= rd_b_p0;
      end
      vld_p1 <= rd_en;
      err_p1 <= err_p0;
    end
  end

  assign out_a     = out_a_p1;
  assign out_b     = out_b_p1;
  assign out_valid = vld_p1;
  assign op_err    = err_p1;

endmodule

// File: doc/reg_bank_switch.md
Name: reg_bank_switch

Overview:
Parametrised register bank with an integrated, registered N:1 read-select switch. It is the next generation of the 4-register select mux in the CPU datapath. It adds NUM_REGS/DATA_W generalisation, a write port, two independent read ports, write-to-read bypass, and a single-cycle register-to-register MOV. It sits between the control unit (select/enable decode) and the ALU operand buses.

Parameters:
DATA_W, 8, register and bus width in bits
NUM_REGS, 4, number of registers (>=2, need not be a power of 2)
SEL_W, 2, select width; must equal clog2(NUM_REGS), checked at elaboration
RESET_VAL, 0, value loaded into every register on reset

Ports:
sys_clk  input  1  clock; all state updates on the rising edge
sys_rst  input  1  synchronous reset, active-high
wr_en  input  1  write R[wr_sel] with wr_data this cycle
wr_sel  input  SEL_W  write / MOV destination index
wr_data  input  DATA_W  write data
mov_en  input  1  copy R[rd_sel_a] into R[wr_sel] this cycle
rd_en  input  1  sample both read ports this cycle
rd_sel_a  input  SEL_W  read port A index; also the MOV source
rd_sel_b  input  SEL_W  read port B index
out_a  output  DATA_W  registered read data, port A
out_b  output  DATA_W  registered read data, port B
out_valid  output  1  out_a/out_b updated by the previous cycle's rd_en
op_err  output  1  one-cycle pulse: illegal or conflicting request

Behaviour:
- Reset: when sys_rst=1 at a clock edge, every R[i]=RESET_VAL, out_a=0, out_b=0, out_valid=0, op_err=0.
  - Reset overrides all other inputs in the same cycle, including mid-write and mid-MOV.
  - Registers stay at RESET_VAL until the first write after reset.
- Write: when wr_en=1 and wr_sel<NUM_REGS, R[wr_sel] takes wr_data at the edge.
- MOV: when mov_en=1, wr_en=0, and both indices are in range, R[wr_sel] takes the pre-edge value of R[rd_sel_a].
  - rd_sel_a==wr_sel is a legal no-op.
- Priority:
  - wr_en=1 with mov_en=1: the write executes, the MOV is dropped, and op_err=1 next cycle.
- Read latency is 1 cycle.
  - When rd_en=1 at edge k, out_a/out_b present the selected data after edge k and out_valid=1 after edge k.
  - When rd_en=0, out_a/out_b hold their last value and out_valid=0.
- Bypass (write-first):
  - If rd_en=1 and a write to index rd_sel_x executes in the same cycle, out_x gets wr_data.
  - If a MOV executes to index rd_sel_x, out_x gets the MOV source value.
  - Both ports bypass independently.
- Out-of-range indices (only possible when NUM_REGS is not a power of 2):
  - A read returns 0 on that port.
  - A write or MOV with an out-of-range wr_sel or source is ignored, and op_err=1 next cycle.
  - An out-of-range read alone does not raise op_err.
- op_err timing: registered; high for exactly one cycle per offending request, then back to 0 unless another offence occurs.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold sys_rst=1 for 2 cycles with wr_en=1 and wr_data=0xFF -> out_a=out_b=0, out_valid=0, op_err=0. A following read of R0..R3 returns 0x00.
- Write/read sweep (defaults): write R0..R3 with 0x10, 0x11, 0x12, 0x13. Then, one cycle each, rd_en=1 with (sel_a, sel_b) = (0,1), (2,3), (3,0) -> next cycle gives out_a/out_b = 0x10/0x11, 0x12/0x13, 0x13/0x10, with out_valid=1 each time.
- Hold: after the sweep, set rd_en=0 for 3 cycles while changing the selects -> out_a/out_b stay 0x13/0x10 and out_valid=0.
- Bypass: R2=0x12; in one cycle set wr_en=1, wr_sel=2, wr_data=0xA5, rd_en=1, rd_sel_a=2, rd_sel_b=1 -> next cycle out_a=0xA5, out_b=0x11. A later read of R2 gives 0xA5.
- MOV and conflict:
  - mov_en=1, rd_sel_a=3, wr_sel=0 -> R0 becomes 0x13.
  - mov_en=1 with wr_en=1, wr_sel=1, wr_data=0x77 -> R1=0x77, no move, op_err pulses exactly 1 cycle.
- Non-power-of-2 (NUM_REGS=5, SEL_W=3):
  - rd_sel_a=6 -> out_a=0, op_err stays 0.
  - wr_en=1, wr_sel=7 -> no register changes, op_err=1 for one cycle.
  - Assert sys_rst mid-sequence -> all outputs 0 on the next cycle.
